// File: rtl/fft8_out_serializer_if.sv
// Handshake bundle for the FFT8 output serializer: parallel 8-point frame in, one sample per beat
// out. The slave modport is the serializer's view; master is the driver/consumer side.
interface fft8_out_serializer_if #(
  parameter int unsigned DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_real [8];
  logic [DW-1:0] in_imag [8];
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_real;
  logic [DW-1:0] out_imag;
  logic [2:0]    out_index;
  logic          out_last;
  logic          busy;

  modport slave (
    input  in_valid, in_real, in_imag, out_ready,
    output in_ready, out_valid, out_real, out_imag, out_index, out_last, busy
  );

  modport master (
    output in_valid, in_real, in_imag, out_ready,
    input  in_ready, out_valid, out_real, out_imag, out_index, out_last, busy
  );
endinterface

// File: rtl/fft8_out_serializer.sv
// Captures one parallel 8-point butterfly frame and replays it as 8 serial valid/ready beats,
// in natural or 3-bit bit-reversed slot order. Frames stream back-to-back without a bubble.
module fft8_out_serializer #(
  parameter int unsigned DW     = 32,
  parameter bit          BITREV = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  fft8_out_serializer_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e        state_q;
  logic [2:0]    cnt_q;
  logic [DW-1:0] re_q [8];
  logic [DW-1:0] im_q [8];
  logic          out_valid_q;
  logic [DW-1:0] out_real_q;
  logic [DW-1:0] out_imag_q;
  logic [2:0]    out_index_q;
  logic          out_last_q;

  logic       accept;
  logic       beat_done;
  logic [2:0] cnt_nxt;
  logic [2:0] slot_nxt;

  function automatic logic [2:0] slot_of(input logic [2:0] c);
    return BITREV ? {c[0], c[1], c[2]} : c;
  endfunction

  // The last beat of a frame frees the buffer in the same cycle, so the next frame lands gap-free.
  assign bus.in_ready = rst_ni && ((state_q == StIdle) ||
                                   ((state_q == StSend) && (cnt_q == 3'd7) && bus.out_ready));
  assign accept    = bus.in_valid && bus.in_ready;
  assign beat_done = out_valid_q && bus.out_ready;
  assign cnt_nxt   = cnt_q + 3'd1;
  assign slot_nxt  = slot_of(cnt_nxt);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      for (int k = 0; k < 8; k++) begin
        re_q[k] <= '0;
        im_q[k] <= '0;
      end
      out_valid_q <= 1'b0;
      out_real_q  <= '0;
      out_imag_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
    end else if (accept) begin
      state_q <= StSend;
      cnt_q   <= '0;
      for (int k = 0; k < 8; k++) begin
        re_q[k] <= bus.in_real[k];
        im_q[k] <= bus.in_imag[k];
      end
      // Slot 0 maps to itself in both orders.
      out_valid_q <= 1'b1;
      out_real_q  <= bus.in_real[0];
      out_imag_q  <= bus.in_imag[0];
      out_index_q <= 3'd0;
      out_last_q  <= 1'b0;
    end else if (beat_done) begin
      if (cnt_q == 3'd7) begin
        // Data and index keep their last values while idle.
        state_q     <= StIdle;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end else begin
        cnt_q       <= cnt_nxt;
        out_real_q  <= re_q[slot_nxt];
        out_imag_q  <= im_q[slot_nxt];
        out_index_q <= slot_nxt;
        out_last_q  <= (cnt_nxt == 3'd7);
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_real  = out_real_q;
  assign bus.out_imag  = out_imag_q;
  assign bus.out_index = out_index_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = (state_q == StSend);

endmodule

// File: tb/tb_fft8_out_serializer.sv
// Directed bench for fft8_out_serializer: natural and bit-reversed instances driven in lockstep.
module tb_fft8_out_serializer;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  fft8_out_serializer_if #(.DW(DW)) if0 ();
  fft8_out_serializer_if #(.DW(DW)) if1 ();

  assign if1.in_valid  = if0.in_valid;
  assign if1.out_ready = if0.out_ready;
  for (genvar k = 0; k < 8; k++) begin : g_mirror
    assign if1.in_real[k] = if0.in_real[k];
    assign if1.in_imag[k] = if0.in_imag[k];
  end

  fft8_out_serializer #(.DW(DW), .BITREV(1'b0)) dut0 (.clk_i(clk), .rst_ni(rst_n), .bus(if0));
  fft8_out_serializer #(.DW(DW), .BITREV(1'b1)) dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(if1));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame(input int base);
    for (int k = 0; k < 8; k++) begin
      if0.in_real[k] = DW'(base + k);
      if0.in_imag[k] = DW'(-(base + k));
    end
  endtask

  task automatic test_reset();
    if0.in_valid  = 1'b0;
    if0.out_ready = 1'b1;
    load_frame(0);
    rst_n = 1'b0;
    #3;
    n_checks++;
    if ({if0.out_valid, if0.out_last, if0.busy, if0.in_ready} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000",
               {if0.out_valid, if0.out_last, if0.busy, if0.in_ready});
    end
    n_checks++;
    if ({if0.out_real, if0.out_imag, if0.out_index} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got real %0h imag %0h idx %0d expected 0 0 0",
               if0.out_real, if0.out_imag, if0.out_index);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_checks++;
    if ({if0.in_ready, if0.out_valid, if0.busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_release: got ready/valid/busy %b expected 100",
               {if0.in_ready, if0.out_valid, if0.busy});
    end
  endtask

  task automatic test_single();
    load_frame(1);
    if0.in_valid = 1'b1;
    #1;
    n_checks++;
    if ({if0.in_ready, if0.out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_precapture: got ready/valid %b expected 10",
               {if0.in_ready, if0.out_valid});
    end
    step();
    if0.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if ({if0.out_valid, if0.busy, if0.out_last} !== {2'b11, i == 7}) begin
        n_fail++;
        $display("FAIL single_flags beat %0d: got valid/busy/last %b expected %b", i,
                 {if0.out_valid, if0.busy, if0.out_last}, {2'b11, i == 7});
      end
      n_checks++;
      if (if0.out_real !== DW'(i + 1) || if0.out_imag !== DW'(-(i + 1)) ||
          if0.out_index !== 3'(i)) begin
        n_fail++;
        $display("FAIL single_data beat %0d: got %0d/%0d idx %0d expected %0d/%0d idx %0d", i,
                 $signed(if0.out_real), $signed(if0.out_imag), if0.out_index,
                 i + 1, -(i + 1), i);
      end
      step();
    end
    n_checks++;
    if ({if0.out_valid, if0.out_last, if0.busy} !== 3'b000 || if0.out_real !== DW'(8) ||
        if0.out_index !== 3'd7) begin
      n_fail++;
      $display("FAIL single_idle: got flags %b real %0d idx %0d expected 000 8 7",
               {if0.out_valid, if0.out_last, if0.busy}, if0.out_real, if0.out_index);
    end
  endtask

  task automatic test_bitrev();
    int exp_re [8];
    int exp_ix [8];
    exp_re = '{1, 5, 3, 7, 2, 6, 4, 8};
    exp_ix = '{0, 4, 2, 6, 1, 5, 3, 7};
    load_frame(1);
    if0.in_valid = 1'b1;
    step();
    if0.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (if1.out_valid !== 1'b1 || if1.out_real !== DW'(exp_re[i]) ||
          if1.out_imag !== DW'(-exp_re[i]) || if1.out_index !== 3'(exp_ix[i]) ||
          if1.out_last !== (i == 7)) begin
        n_fail++;
        $display("FAIL bitrev beat %0d: got v%b re %0d idx %0d last %b expected v1 re %0d idx %0d",
                 i, if1.out_valid, $signed(if1.out_real), if1.out_index, if1.out_last,
                 exp_re[i], exp_ix[i]);
      end
      step();
    end
    n_checks++;
    if (if1.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bitrev_end: got valid %b expected 0", if1.out_valid);
    end
  endtask

  task automatic test_backpressure();
    int beats = 0;
    load_frame(1);
    if0.in_valid = 1'b1;
    step();
    if0.in_valid = 1'b0;
    for (int cyc = 0; cyc < 40 && beats < 8; cyc++) begin
      if0.out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      n_checks++;
      if (if0.out_valid !== 1'b1 || if0.out_real !== DW'(beats + 1) ||
          if0.out_index !== 3'(beats)) begin
        n_fail++;
        $display("FAIL backpressure cyc %0d: got v%b re %0d idx %0d expected v1 re %0d idx %0d",
                 cyc, if0.out_valid, if0.out_real, if0.out_index, beats + 1, beats);
      end
      if (if0.out_ready) beats++;
      step();
    end
    if0.out_ready = 1'b1;
    n_checks++;
    if (beats != 8 || if0.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_total: got %0d beats valid %b expected 8 beats valid 0",
               beats, if0.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    load_frame(1);
    if0.in_valid = 1'b1;
    step();
    load_frame(9);
    for (int n = 1; n <= 16; n++) begin
      if (n == 9) if0.in_valid = 1'b0;
      #1;
      n_checks++;
      if (if0.out_valid !== 1'b1 || if0.out_real !== DW'(n) ||
          if0.out_last !== (n == 8 || n == 16)) begin
        n_fail++;
        $display("FAIL b2b beat %0d: got v%b re %0d last %b expected v1 re %0d last %b", n,
                 if0.out_valid, if0.out_real, if0.out_last, n, (n == 8 || n == 16));
      end
      if (n <= 8) begin
        n_checks++;
        if (if0.in_ready !== (n == 8)) begin
          n_fail++;
          $display("FAIL b2b_ready beat %0d: got %b expected %b", n, if0.in_ready, (n == 8));
        end
      end
      step();
    end
    n_checks++;
    if (if0.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: got valid %b expected 0", if0.out_valid);
    end
  endtask

  task automatic test_ignore();
    load_frame(1);
    if0.in_valid = 1'b1;
    step();
    if0.in_valid = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      if (n == 4) begin
        load_frame(9);
        if0.in_valid = 1'b1;
      end
      if (n == 9) if0.in_valid = 1'b0;
      #1;
      n_checks++;
      if (if0.out_valid !== 1'b1 || if0.out_real !== DW'(n) || if0.out_imag !== DW'(-n)) begin
        n_fail++;
        $display("FAIL ignore beat %0d: got v%b re %0d im %0d expected v1 re %0d im %0d", n,
                 if0.out_valid, $signed(if0.out_real), $signed(if0.out_imag), n, -n);
      end
      if (n >= 4 && n <= 7) begin
        n_checks++;
        if (if0.in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL ignore_ready beat %0d: got %b expected 0", n, if0.in_ready);
        end
      end
      step();
    end
    n_checks++;
    if (if0.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_end: got valid %b expected 0", if0.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    load_frame(1);
    if0.in_valid = 1'b1;
    step();
    if0.in_valid = 1'b0;
    repeat (4) step();
    n_checks++;
    if (if0.out_real !== DW'(5)) begin
      n_fail++;
      $display("FAIL rstmid_pre: got re %0d expected 5", if0.out_real);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({if0.out_valid, if0.out_last, if0.busy, if0.in_ready} !== 4'b0000 ||
        {if0.out_real, if0.out_imag, if0.out_index} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async: got flags %b re %0h im %0h idx %0d expected all 0",
               {if0.out_valid, if0.out_last, if0.busy, if0.in_ready},
               if0.out_real, if0.out_imag, if0.out_index);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_checks++;
    if ({if0.in_ready, if0.out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL rstmid_release: got ready/valid %b expected 10",
               {if0.in_ready, if0.out_valid});
    end
    load_frame(21);
    if0.in_valid = 1'b1;
    step();
    if0.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (if0.out_valid !== 1'b1 || if0.out_real !== DW'(21 + i) ||
          if0.out_index !== 3'(i)) begin
        n_fail++;
        $display("FAIL rstmid_frame beat %0d: got v%b re %0d idx %0d expected v1 re %0d idx %0d",
                 i, if0.out_valid, if0.out_real, if0.out_index, 21 + i, i);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_bitrev();
    test_backpressure();
    test_back_to_back();
    test_ignore();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fft8_out_serializer.md
FFT8_OUT_SERIALIZER -- requirements
Module: fft8_out_serializer

Interface
REQ-001 Parameter DW, default 32: width of each real/imag component, two's complement.
REQ-002 Parameter BITREV, default 0: 0 = emit slots in natural order 0..7; 1 = emit slots in 3-bit bit-reversed order 0,4,2,6,1,5,3,7.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  the 8-point frame on in<k>_* is valid.
REQ-006 in_ready  output  1  the block can accept a frame this cycle.
REQ-007 in<k>_real, in<k>_imag (k=0..7)  input  DW each  parallel outputs of one 8-point butterfly stage.
REQ-008 out_valid  output  1  out_real/out_imag hold a valid sample.
REQ-009 out_ready  input  1  the downstream accepts the sample this cycle.
REQ-010 out_real, out_imag  output  DW each  current serial sample.
REQ-011 out_index  output  3  source slot k of the current sample.
REQ-012 out_last  output  1  high with the 8th sample of a frame.
REQ-013 busy  output  1  high while a frame is held (state SEND).

Function
REQ-014 The block SHALL have two states: IDLE (no frame held) and SEND (frame held, beat counter cnt 0..7 active).
REQ-015 A frame SHALL be accepted when in_valid && in_ready; all 16 inputs are copied into an internal frame buffer on that edge and cnt is set to 0.
REQ-016 in_ready SHALL be (state==IDLE) || (state==SEND && cnt==7 && out_ready), combinationally, so frames stream back-to-back with no bubble.
REQ-017 On acceptance, state SHALL become SEND and out_valid SHALL assert on the next cycle (latency 1 clock from capture to first beat).
REQ-018 In SEND, out_valid SHALL be 1. out_real/out_imag SHALL be the buffered slot s, where s = cnt if BITREV=0, and s = {cnt[0],cnt[1],cnt[2]} if BITREV=1.
REQ-019 out_index SHALL equal s. out_last SHALL equal (cnt==7).
REQ-020 A beat SHALL complete when out_valid && out_ready, and cnt SHALL then increment. While out_ready=0, cnt, the buffer and all outputs SHALL hold stable.
REQ-021 When the beat with cnt==7 completes and no new frame is accepted in the same cycle, state SHALL return to IDLE and out_valid SHALL drop on the next cycle.
REQ-022 When the beat with cnt==7 completes in the same cycle that a new frame is accepted, the buffer SHALL load the new frame, cnt SHALL be 0, state SHALL stay SEND, and out_valid SHALL remain high.
REQ-023 In_valid while in_ready=0 SHALL be ignored; the held frame SHALL NOT be corrupted.
REQ-024 Data SHALL pass unmodified, with no scaling, rounding or sign change. The block has no arithmetic beyond the 3-bit counter.
REQ-025 In IDLE: out_valid=0, out_last=0, busy=0. out_real/out_imag/out_index SHALL hold their last values.

Reset
REQ-026 Asserting rst low SHALL immediately, without a clock, force: state IDLE, cnt=0, buffer=0, out_valid=0, out_last=0, out_index=0, out_real=0, out_imag=0, busy=0.
REQ-027 in_ready SHALL be 0 while rst is low and 1 on the first cycle after release.
REQ-028 Reset mid-frame SHALL discard the remaining beats. After release, the first accepted frame SHALL start at cnt=0.

Verification
REQ-029 Single frame, BITREV=0, in<k>_real=k+1, in<k>_imag=-(k+1), out_ready=1 -> out_valid high for exactly 8 cycles, starting 1 cycle after capture. Reals are 1..8, imags are -1..-8, out_index is 0..7, out_last is high only on real=8. Then out_valid drops.
REQ-030 Same frame with BITREV=1 -> out_real sequence is 1,5,3,7,2,6,4,8 and out_index sequence is 0,4,2,6,1,5,3,7.
REQ-031 Backpressure: out_ready toggled 1,0,0,1,... -> each sample is held stable while out_ready=0. There are no duplicated or dropped samples, and the total is 8 accepted beats.
REQ-032 Back-to-back: frame A (reals 1..8), then frame B (reals 9..16) presented with in_valid held high -> in_ready pulses in the cycle of A's last beat. 16 consecutive valid beats 1..16 follow, with no idle cycle and with out_last on 8 and 16.
REQ-033 in_valid asserted at cnt=3 with B data -> ignored. A completes unchanged and B is accepted only when in_ready=1.
REQ-034 rst pulsed low at cnt=4 of a frame -> all outputs are 0 asynchronously. After release, a new frame with reals 21..28 emits 21 first, at cnt=0.
